// File: rtl/argmin_sequencer.sv
// Sequential argmin search over up to eight 12-bit cost values, one entry per cycle.
// Optional per-entry eligibility mask enabled by defining ARGMIN_MASK_EN.
module argmin_sequencer (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [11:0] vals_in0,
  input  logic [11:0] vals_in1,
  input  logic [11:0] vals_in2,
  input  logic [11:0] vals_in3,
  input  logic [11:0] vals_in4,
  input  logic [11:0] vals_in5,
  input  logic [11:0] vals_in6,
  input  logic [11:0] vals_in7,
  input  logic [2:0]  num_in,
`ifdef ARGMIN_MASK_EN
  input  logic [7:0]  mask_in,
`endif
  input  logic        start_in,
  input  logic        ack_in,
  output logic        busy_out,
  output logic        valid_out,
  output logic [2:0]  min_index_out,
  output logic [11:0] min_value_out,
  output logic        none_out
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state;
  logic [11:0] vals_q [8];
  logic [2:0]  num_q;
  logic [2:0]  ptr;
  logic        have_q;
  logic [11:0] run_val;
  logic [2:0]  run_idx;
  logic [7:0]  elig;

  logic        take;
  logic        nxt_have;
  logic [11:0] nxt_val;
  logic [2:0]  nxt_idx;

`ifdef ARGMIN_MASK_EN
  logic [7:0]  mask_q;
  logic        none_q;
  assign elig     = mask_q;
  assign none_out = none_q;
`else
  assign elig     = '1;
  assign none_out = 1'b0;
`endif

  // Running-minimum update for the entry under the pointer; strict compare keeps the lowest index on ties.
  always_comb begin
    take     = elig[ptr] && (!have_q || (vals_q[ptr] < run_val));
    nxt_have = have_q || take;
    nxt_val  = take ? vals_q[ptr] : run_val;
    nxt_idx  = take ? ptr : run_idx;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      for (int unsigned i = 0; i < 8; i++) vals_q[i] <= '0;
      num_q         <= '0;
      ptr           <= '0;
      have_q        <= 1'b0;
      run_val       <= '0;
      run_idx       <= '0;
      busy_out      <= 1'b0;
      valid_out     <= 1'b0;
      min_index_out <= '0;
      min_value_out <= '0;
`ifdef ARGMIN_MASK_EN
      mask_q        <= '0;
      none_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            vals_q[0] <= vals_in0;
            vals_q[1] <= vals_in1;
            vals_q[2] <= vals_in2;
            vals_q[3] <= vals_in3;
            vals_q[4] <= vals_in4;
            vals_q[5] <= vals_in5;
            vals_q[6] <= vals_in6;
            vals_q[7] <= vals_in7;
            num_q     <= num_in;
`ifdef ARGMIN_MASK_EN
            mask_q    <= mask_in;
`endif
            ptr       <= '0;
            have_q    <= 1'b0;
            run_val   <= '0;
            run_idx   <= '0;
            busy_out  <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          have_q  <= nxt_have;
          run_val <= nxt_val;
          run_idx <= nxt_idx;
          if (ptr == num_q) begin
            // The last entry's evaluation feeds the result registers directly.
            min_index_out <= nxt_have ? nxt_idx : 3'd0;
            min_value_out <= nxt_have ? nxt_val : 12'hFFF;
`ifdef ARGMIN_MASK_EN
            none_q        <= !nxt_have;
`endif
            valid_out     <= 1'b1;
            state         <= DONE;
          end else begin
            ptr <= ptr + 3'd1;
          end
        end
        DONE: begin
          if (ack_in) begin
            valid_out <= 1'b0;
            busy_out  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argmin_sequencer.sv
// Scoreboard bench for argmin_sequencer: the driver queues expected results,
// a negedge monitor checks every DONE (value, index, latency, stability).
module tb_argmin_sequencer;

  logic        clk;
  logic        rst_n;
  logic [11:0] tv [8];
  logic [2:0]  num_in;
  logic        start_in;
  logic        ack_in;
  logic        busy_out;
  logic        valid_out;
  logic [2:0]  min_index_out;
  logic [11:0] min_value_out;
  logic        none_out;

  argmin_sequencer dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .vals_in0      (tv[0]),
    .vals_in1      (tv[1]),
    .vals_in2      (tv[2]),
    .vals_in3      (tv[3]),
    .vals_in4      (tv[4]),
    .vals_in5      (tv[5]),
    .vals_in6      (tv[6]),
    .vals_in7      (tv[7]),
    .num_in        (num_in),
    .start_in      (start_in),
    .ack_in        (ack_in),
    .busy_out      (busy_out),
    .valid_out     (valid_out),
    .min_index_out (min_index_out),
    .min_value_out (min_value_out),
    .none_out      (none_out)
  );

  typedef struct {
    logic [2:0]  idx;
    logic [11:0] val;
    logic        none;
    int unsigned due;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  bit          have_cur;
  bit          prev_v;
  int unsigned cyc;
  int          tests;
  int          fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per rising valid, then checks outputs every cycle valid stays high.
  initial begin
    have_cur = 1'b0;
    prev_v   = 1'b0;
    forever begin
      @(negedge clk);
      if (valid_out && !prev_v) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_done: valid rose with no pending search (cycle %0d)", cyc);
          have_cur = 1'b0;
        end else begin
          cur      = q.pop_front();
          have_cur = 1'b1;
          check("latency_cycle", cyc, cur.due);
        end
      end
      if (valid_out && have_cur) begin
        check("min_index", min_index_out, cur.idx);
        check("min_value", min_value_out, cur.val);
        check("none", none_out, cur.none);
        check("busy_in_done", busy_out, 1);
      end
      if (!valid_out) have_cur = 1'b0;
      prev_v = valid_out;
    end
  end

  task automatic set_tv(input logic [11:0] a, b, c, d, e, f, g, h);
    tv[0] = a; tv[1] = b; tv[2] = c; tv[3] = d;
    tv[4] = e; tv[5] = f; tv[6] = g; tv[7] = h;
  endtask

  task automatic search(input logic [2:0] num, input logic [2:0] eidx, input logic [11:0] eval,
                        input int hold, input bit pulse_scan, input bit pulse_done);
    exp_t e;
    int   n;
    @(negedge clk);
    num_in   = num;
    start_in = 1'b1;
    e.idx  = eidx;
    e.val  = eval;
    e.none = 1'b0;
    e.due  = cyc + num + 2;
    q.push_back(e);
    @(negedge clk);
    start_in = 1'b0;
    check("busy_after_start", busy_out, 1);
    if (pulse_scan) begin
      set_tv(12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001);
      num_in   = 3'd0;
      start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
    end
    n = 0;
    while (!valid_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!valid_out) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: valid_out=0 after 20 cycles, expected 1");
      return;
    end
    repeat (hold) @(negedge clk);
    if (pulse_done) begin
      start_in = 1'b1;
      @(negedge clk);
      ack_in = 1'b1;
      @(negedge clk);
      ack_in   = 1'b0;
      start_in = 1'b0;
    end else begin
      ack_in = 1'b1;
      @(negedge clk);
      ack_in = 1'b0;
    end
    check("valid_after_ack", valid_out, 0);
    check("busy_after_ack", busy_out, 0);
    check("retained_value", min_value_out, eval);
    check("retained_index", min_index_out, eidx);
    if (pulse_done) begin
      repeat (3) @(negedge clk);
      check("no_start_with_ack", busy_out, 0);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    num_in   = '0;
    start_in = 1'b0;
    ack_in   = 1'b0;
    set_tv('0, '0, '0, '0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    check("reset_busy", busy_out, 0);
    check("reset_valid", valid_out, 0);
    check("reset_index", min_index_out, 0);
    check("reset_value", min_value_out, 0);
    check("reset_none", none_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_value_before_first_done", min_value_out, 0);

    set_tv(12'd100, 12'd50, 12'd75, 12'd50, 12'd200, 12'd10, 12'd300, 12'd5);
    search(3'd7, 3'd7, 12'd5, 0, 1'b0, 1'b0);
    search(3'd3, 3'd1, 12'd50, 2, 1'b0, 1'b0);
    set_tv(12'hABC, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001);
    search(3'd0, 3'd0, 12'hABC, 5, 1'b0, 1'b0);
    set_tv(12'h123, 12'h123, 12'h123, 12'h123, 12'h123, 12'h123, 12'h123, 12'h123);
    search(3'd7, 3'd0, 12'h123, 0, 1'b0, 1'b0);
    set_tv(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
    search(3'd7, 3'd0, 12'hFFF, 1, 1'b0, 1'b0);
    set_tv(12'd500, 12'd400, 12'd3, 12'd3, 12'd0, 12'd0, 12'd0, 12'd0);
    search(3'd2, 3'd2, 12'd3, 1, 1'b1, 1'b1);
    set_tv(12'd100, 12'd50, 12'd75, 12'd50, 12'd200, 12'd10, 12'd300, 12'd5);
    search(3'd7, 3'd7, 12'd5, 2, 1'b1, 1'b1);

    // Reset in the 3rd SCAN cycle of a full-length search; that search must never complete.
    set_tv(12'd100, 12'd50, 12'd75, 12'd50, 12'd200, 12'd10, 12'd300, 12'd5);
    @(negedge clk);
    num_in   = 3'd7;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midscan_rst_busy", busy_out, 0);
    check("midscan_rst_valid", valid_out, 0);
    check("midscan_rst_index", min_index_out, 0);
    check("midscan_rst_value", min_value_out, 0);
    check("midscan_rst_none", none_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no_done_after_rst", busy_out, 0);
    set_tv(12'd9, 12'd4, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0);
    search(3'd1, 3'd1, 12'd4, 0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/argmin_sequencer.md
ARGMIN_SEQUENCER -- requirements
Module: argmin_sequencer

Interface
REQ-001 The block SHALL have port clk_in, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have ports vals_in0..vals_in7, input, 12 bits each: candidate cost values, sampled only at start accept.
REQ-004 The block SHALL have port num_in, input, 3 bits: index of the last candidate to scan (num_in+1 entries, 1..8), sampled at start accept.
REQ-005 The block SHALL have port start_in, input, 1 bit: request a new search.
REQ-006 The block SHALL have port ack_in, input, 1 bit: consumer accepts the presented result.
REQ-007 The block SHALL have port busy_out, output, 1 bit: high in SCAN and DONE.
REQ-008 The block SHALL have port valid_out, output, 1 bit: result valid, high only in DONE.
REQ-009 The block SHALL have port min_index_out, output, 3 bits: index of the minimum.
REQ-010 The block SHALL have port min_value_out, output, 12 bits: value of the minimum.
REQ-011 The block SHALL have port none_out, output, 1 bit: no eligible entry was found.

Function
REQ-012 The block SHALL implement three states: IDLE, SCAN, DONE.
REQ-013 In IDLE, start_in high at edge E0 SHALL latch all vals, num_in and mask, set the scan pointer to 0, and enter SCAN.
REQ-014 start_in SHALL be ignored outside IDLE.
REQ-015 In SCAN, one entry (the pointer) SHALL be evaluated per cycle, in ascending index order.
REQ-016 An eligible entry SHALL replace the running minimum if no minimum is held yet or if its value is strictly less (unsigned) than the minimum; ties SHALL keep the lowest index.
REQ-017 After evaluating pointer == latched num, the block SHALL enter DONE, so valid_out rises after edge E0+num+1 (latency 1..8 cycles).
REQ-018 In DONE, min_index_out, min_value_out and none_out SHALL hold stable until ack_in is sampled high; the block SHALL then return to IDLE, with valid_out low after that edge.
REQ-019 start_in SHALL NOT be accepted in the same cycle as ack_in.
REQ-020 If no entry was eligible, DONE SHALL present none_out=1, min_index_out=0 and min_value_out=12'hFFF.
REQ-021 Result outputs SHALL be zero in IDLE until the first DONE, and SHALL retain the last result in IDLE afterwards.
REQ-022 The pointer SHALL never exceed 7 and SHALL never wrap.

Reset
REQ-023 Asserting rst_n_in low at any time, including mid-SCAN or in DONE, SHALL immediately force IDLE and drive all outputs to 0; any scan in progress SHALL be discarded.
REQ-024 After reset deassertion, the first accepted start SHALL behave identically to a start after power-up.

Configuration
REQ-025 With ARGMIN_MASK_EN defined, an 8-bit input port mask_in SHALL exist and SHALL be latched at start; an entry with its mask bit at 0 SHALL be ineligible.
REQ-026 Without ARGMIN_MASK_EN, mask_in SHALL be absent, all entries up to num SHALL be eligible, and none_out SHALL be constant 0.

Verification
REQ-027 vals = {100,50,75,50,200,10,300,5}, num_in=7, start -> valid_out after 8 cycles, index=7, value=5.
REQ-028 Same vals, num_in=3 -> valid_out after 4 cycles, index=1, value=50 (tie with index 3 resolved to the lower index).
REQ-029 num_in=0, vals_in0=12'hABC -> valid_out after 1 cycle, index=0, value=ABC; hold ack_in low for 5 cycles -> outputs stable; ack -> IDLE.
REQ-030 Start with num_in=7, assert rst_n_in low in the 3rd SCAN cycle -> all outputs 0 immediately; a new start with num_in=1, vals {9,4} -> index=1, value=4.
REQ-031 ARGMIN_MASK_EN defined: mask_in=8'h00, num_in=7 -> none_out=1, value=FFF, index=0. mask_in=8'b0111_1111 with the vals of REQ-027 -> index=5, value=10.
REQ-032 start_in pulsed during SCAN and during DONE -> ignored: the result is unchanged and exactly one DONE occurs per accepted start.
